// File: rtl/nios2_debug_vjtag_host.sv
// nios2_debug_vjtag_host
//   Initiator side of the Nios II debug-slave virtual-JTAG interface. Each
//   accepted command runs one scan: UIR -> CDR -> SDR (DR_WIDTH bits) -> UDR
//   -> RTI. The DR bits captured from vji_tdo and the vji_ir_out value sampled
//   in CDR are returned on a valid/ready response port.
//
// Ports
//   clk, reset_n            single clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_ir, cmd_data        virtual IR value and DR bits (bit 0 shifted first)
//   rsp_valid/rsp_ready     response handshake (valid held until accepted)
//   rsp_data, rsp_ir_out    captured tdo bits (bit 0 first) and slave status
//   vji_tck, vji_tdi        generated tck and serial data to the slave
//   vji_tdo, vji_ir_out     serial data and IR status from the slave
//   vji_ir_in               virtual IR, held until the next UIR
//   vji_uir/cdr/sdr/udr/rti virtual state indicators (at most one high)
//
// Every tck period is 2*TCK_HALF clk: tck low for the first half, high for
// the second. Strobes and tdi only change on the edge that starts a period;
// DUT-side captures happen on the edge that raises tck.

module nios2_debug_vjtag_host #(
    parameter int unsigned DR_WIDTH   = 38,
    parameter int unsigned IR_WIDTH   = 2,
    parameter int unsigned TCK_HALF   = 2,
    parameter int unsigned RTI_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned P  = 2 * TCK_HALF;
    localparam int unsigned PW = $clog2(P);
    localparam int unsigned BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam int unsigned RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

    // ST_LAUNCH is the one clk between accepting a command and the edge that
    // opens the UIR period.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ph_q, ph_d;        // clk count within the tck period
    logic [BW-1:0]       bit_q, bit_d;      // SDR bit index
    logic [RW-1:0]       rcnt_q, rcnt_d;    // RTI period count
    logic [DR_WIDTH-1:0] data_q, data_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;

    logic                cmd_ready_d;
    logic                rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_data_d;
    logic [IR_WIDTH-1:0] rsp_ir_out_d;
    logic                tck_d;
    logic                tdi_d;
    logic [IR_WIDTH-1:0] ir_in_d;
    logic                uir_d, cdr_d, sdr_d, udr_d, rti_d;

    logic                period_end;
    logic                tck_rise;
    logic                scan_d;

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        bit_d        = bit_q;
        rcnt_d       = rcnt_q;
        data_d       = data_q;
        ir_d         = ir_q;
        rsp_data_d   = rsp_data;
        rsp_ir_out_d = rsp_ir_out;
        ir_in_d      = vji_ir_in;

        period_end = (ph_q == PW'(P - 1));
        tck_rise   = (ph_q == PW'(TCK_HALF - 1));

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    data_d  = cmd_data;
                    ir_d    = cmd_ir;
                    state_d = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                state_d = ST_UIR;
                ph_d    = '0;
                ir_in_d = ir_q;
            end

            ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI: begin
                ph_d = period_end ? '0 : ph_q + PW'(1);

                if (tck_rise) begin
                    if (state_q == ST_CDR) begin
                        rsp_ir_out_d = vji_ir_out;
                    end
                    if (state_q == ST_SDR) begin
                        rsp_data_d[bit_q] = vji_tdo;
                    end
                end

                if (period_end) begin
                    case (state_q)
                        ST_UIR: state_d = ST_CDR;
                        ST_CDR: begin
                            state_d = ST_SDR;
                            bit_d   = '0;
                        end
                        ST_SDR: begin
                            if (bit_q == BW'(DR_WIDTH - 1)) begin
                                state_d = ST_UDR;
                                bit_d   = '0;
                            end else begin
                                bit_d = bit_q + BW'(1);
                            end
                        end
                        ST_UDR: begin
                            state_d = ST_RTI;
                            rcnt_d  = '0;
                        end
                        ST_RTI: begin
                            if (rcnt_q == RW'(RTI_CYCLES - 1)) begin
                                state_d = ST_RESP;
                                rcnt_d  = '0;
                            end else begin
                                rcnt_d = rcnt_q + RW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies, so
        // strobes and tdi settle on the same edge that starts a period.
        scan_d      = (state_d inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI});
        tck_d       = scan_d && (ph_d >= PW'(TCK_HALF));
        tdi_d       = (state_d == ST_SDR) && data_d[bit_d];
        uir_d       = (state_d == ST_UIR);
        cdr_d       = (state_d == ST_CDR);
        sdr_d       = (state_d == ST_SDR);
        udr_d       = (state_d == ST_UDR);
        rti_d       = (state_d inside {ST_RTI, ST_RESP, ST_IDLE, ST_LAUNCH});
        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            bit_q      <= '0;
            rcnt_q     <= '0;
            data_q     <= '0;
            ir_q       <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b1;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            rcnt_q     <= rcnt_d;
            data_q     <= data_d;
            ir_q       <= ir_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_ir_out <= rsp_ir_out_d;
            vji_tck    <= tck_d;
            vji_tdi    <= tdi_d;
            vji_ir_in  <= ir_in_d;
            vji_uir    <= uir_d;
            vji_cdr    <= cdr_d;
            vji_sdr    <= sdr_d;
            vji_udr    <= udr_d;
            vji_rti    <= rti_d;
        end
    end

endmodule

// File: tb/tb_nios2_debug_vjtag_host.sv
// tb_nios2_debug_vjtag_host
//   Two hosts are instantiated (TCK_HALF=2 and TCK_HALF=1) sharing command
//   inputs; "sel" routes cmd_valid/rsp_ready to one of them and picks which
//   one the checks observe. Each host talks to a simple slave shift register.

module tb_nios2_debug_vjtag_host;

    localparam int unsigned DR  = 38;
    localparam int unsigned IRW = 2;
    localparam int unsigned RTI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n, cmd_valid, rsp_ready, sel;
    logic [IRW-1:0] cmd_ir, ir_out;
    logic [DR-1:0]  cmd_data;

    logic           cmd_valid0, rsp_ready0, cmd_ready0, rsp_valid0;
    logic           tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
    logic [DR-1:0]  rsp_data0;
    logic [IRW-1:0] rsp_ir_out0, ir_in0;

    logic           cmd_valid1, rsp_ready1, cmd_ready1, rsp_valid1;
    logic           tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
    logic [DR-1:0]  rsp_data1;
    logic [IRW-1:0] rsp_ir_out1, ir_in1;

    assign cmd_valid0 = cmd_valid & ~sel;
    assign rsp_ready0 = rsp_ready & ~sel;
    assign cmd_valid1 = cmd_valid & sel;
    assign rsp_ready1 = rsp_ready & sel;

    nios2_debug_vjtag_host #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_HALF(2), .RTI_CYCLES(RTI)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0), .rsp_ir_out(rsp_ir_out0),
        .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0), .vji_ir_in(ir_in0), .vji_ir_out(ir_out),
        .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
    );

    nios2_debug_vjtag_host #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_HALF(1), .RTI_CYCLES(RTI)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_ir_out(rsp_ir_out1),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir_in1), .vji_ir_out(ir_out),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    // Slave models: a DR-bit shift register, tdo = bit 0, shifting tdi in at
    // the top on every tck rising edge seen while sdr is high.
    logic [DR-1:0] sr0, sr1, load_val;
    logic          load0, load1, tck0_p, tck1_p;

    always @(posedge clk) begin
        tck0_p <= tck0;
        if (load0) sr0 <= load_val;
        else if (tck0 && !tck0_p && sdr0) sr0 <= {tdi0, sr0[DR-1:1]};
    end

    always @(posedge clk) begin
        tck1_p <= tck1;
        if (load1) sr1 <= load_val;
        else if (tck1 && !tck1_p && sdr1) sr1 <= {tdi1, sr1[DR-1:1]};
    end

    assign tdo0 = sr0[0];
    assign tdo1 = sr1[0];

    // Observed host (selected by sel)
    logic           m_cmd_ready, m_rsp_valid, m_tck, m_tdi, m_uir, m_cdr, m_sdr, m_udr, m_rti;
    logic [DR-1:0]  m_rsp_data, m_sr;
    logic [IRW-1:0] m_rsp_ir_out, m_ir_in;

    assign m_cmd_ready  = sel ? cmd_ready1  : cmd_ready0;
    assign m_rsp_valid  = sel ? rsp_valid1  : rsp_valid0;
    assign m_tck        = sel ? tck1        : tck0;
    assign m_tdi        = sel ? tdi1        : tdi0;
    assign m_uir        = sel ? uir1        : uir0;
    assign m_cdr        = sel ? cdr1        : cdr0;
    assign m_sdr        = sel ? sdr1        : sdr0;
    assign m_udr        = sel ? udr1        : udr0;
    assign m_rti        = sel ? rti1        : rti0;
    assign m_rsp_data   = sel ? rsp_data1   : rsp_data0;
    assign m_rsp_ir_out = sel ? rsp_ir_out1 : rsp_ir_out0;
    assign m_ir_in      = sel ? ir_in1      : ir_in0;
    assign m_sr         = sel ? sr1         : sr0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        bit             s;
        logic [IRW-1:0] ir;
        logic [DR-1:0]  data;
        logic [DR-1:0]  pre;
        logic [IRW-1:0] iro;
        int             hold;
        logic [DR-1:0]  exp_rsp;
        logic [DR-1:0]  exp_sr;
        logic [IRW-1:0] exp_iro;
        int             exp_lat;
    } vec_t;

    // Scan = UIR + CDR + DR SDR periods + UDR + RTI periods, each 2*TCK_HALF
    // clk, plus one clk from accept to the first period.
    function automatic int lat_for(bit s);
        return 1 + (DR + 3 + RTI) * (s ? 2 : 4);
    endfunction

    function automatic vec_t mk(bit s, logic [IRW-1:0] ir, logic [DR-1:0] data,
                                logic [DR-1:0] pre, logic [IRW-1:0] iro, int hold);
        vec_t v;
        v.s = s; v.ir = ir; v.data = data; v.pre = pre; v.iro = iro; v.hold = hold;
        v.exp_rsp = pre;     // slave's preloaded contents come back out
        v.exp_sr  = data;    // and the command data ends up in the slave
        v.exp_iro = iro;
        v.exp_lat = lat_for(s);
        return v;
    endfunction

    function automatic logic [DR-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DR-1:0];
    endfunction

    task automatic load_slave(input bit s, input logic [DR-1:0] val);
        load_val = val;
        if (s) load1 = 1'b1; else load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k, n_uir, n_cdr, n_sdr, n_udr, n_rti, viol, ir_bad;
        bit udr_seen;
        logic [DR-1:0] sr_udr;
        logic prev_tck;
        logic [IRW-1:0] prev_ir;

        sel    = v.s;
        ir_out = v.iro;
        load_slave(v.s, v.pre);
        chk({tag, "_ready_idle"}, m_cmd_ready, 1);

        cmd_valid = 1'b1;
        cmd_ir    = v.ir;
        cmd_data  = v.data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_ir    = ~v.ir;
        cmd_data  = ~v.data;

        k = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
        viol = 0; ir_bad = 0; udr_seen = 0; sr_udr = '0;
        prev_tck = m_tck;
        prev_ir  = m_ir_in;
        while (!m_rsp_valid && k < 2000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if ($countones({m_uir, m_cdr, m_sdr, m_udr, m_rti}) > 1) viol++;
            if (m_tck && !prev_tck) begin
                if (m_uir) n_uir++;
                if (m_cdr) n_cdr++;
                if (m_sdr) n_sdr++;
                if (m_udr) n_udr++;
                if (m_rti) n_rti++;
            end
            if (m_ir_in !== prev_ir && !m_uir) ir_bad++;
            if (m_udr && !udr_seen) begin
                udr_seen = 1;
                sr_udr   = m_sr;
            end
            prev_tck = m_tck;
            prev_ir  = m_ir_in;
        end

        chk({tag, "_latency"},    k, v.exp_lat);
        chk({tag, "_rsp_data"},   m_rsp_data, v.exp_rsp);
        chk({tag, "_rsp_ir_out"}, m_rsp_ir_out, v.exp_iro);
        chk({tag, "_ir_in"},      m_ir_in, v.ir);
        chk({tag, "_slave_udr"},  sr_udr, v.exp_sr);
        chk({tag, "_rises"},      {n_uir[7:0], n_cdr[7:0], n_sdr[7:0], n_udr[7:0], n_rti[7:0]},
                                  {8'd1, 8'd1, DR[7:0], 8'd1, RTI[7:0]});
        chk({tag, "_onehot"},     viol, 0);
        chk({tag, "_ir_only_uir"}, ir_bad, 0);

        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            cmd_ir    = ~v.ir;
            cmd_data  = rnd();
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_backpressure"}, {m_rsp_valid, m_cmd_ready, m_rsp_ir_out, m_rsp_data},
                {1'b1, 1'b0, v.exp_iro, v.exp_rsp});
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({tag, "_handshake"}, {m_rsp_valid, m_cmd_ready, m_uir}, {1'b0, 1'b1, 1'b0});
    endtask

    vec_t vecs[9];

    initial begin
        int n, cnt;
        logic prev;

        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
        load0 = 1'b0; load1 = 1'b0; load_val = '0;
        ir_out = '0; cmd_ir = '0; cmd_data = '0;

        vecs[0] = mk(0, 2'b10, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 2'b11, 0);
        vecs[1] = mk(1, 2'b01, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 2'b10, 0);
        vecs[2] = mk(0, 2'b11, rnd(), rnd(), 2'b10, 10);
        vecs[3] = mk(0, 2'b00, rnd(), rnd(), 2'b01, 0);
        vecs[4] = mk(0, 2'b11, rnd(), rnd(), 2'b01, 0);
        for (int i = 5; i < 9; i++) begin
            vecs[i] = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd(), rnd(),
                         2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("reset_strobes0", {uir0, cdr0, sdr0, udr0, rti0, tck0, rsp_valid0, cmd_ready0, tdi0}, 9'b000010000);
        chk("reset_strobes1", {uir1, cdr1, sdr1, udr1, rti1, tck1, rsp_valid1, cmd_ready1, tdi1}, 9'b000010000);
        chk("reset_regs0", {rsp_data0, rsp_ir_out0, ir_in0}, '0);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", {cmd_ready0, cmd_ready1}, 2'b11);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of SDR, after bit 17 has been captured.
        sel = 1'b0;
        load_slave(0, rnd());
        cmd_valid = 1'b1;
        cmd_data  = rnd();
        cmd_ir    = 2'b01;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 0; n = 0; prev = m_tck;
        while (cnt < 18 && n < 2000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (m_tck && !prev && m_sdr) cnt++;
            prev = m_tck;
        end
        chk("midscan_bits", cnt, 18);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midscan_reset", {m_uir, m_cdr, m_sdr, m_udr, m_rti, m_tck, m_rsp_valid, m_cmd_ready, m_tdi},
                9'b000010000);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midscan_ready", m_cmd_ready, 1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_rsp_valid) n++;
        end
        chk("midscan_no_rsp", n, 0);
        run_vec(mk(0, 2'b10, rnd(), rnd(), 2'b01, 0), "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
